pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Central hazard sequencer for the 5-stage RISC-V pipeline.
- Consumes the load-use hazard flag from the EX-stage forwarding unit, the I/D cache handshakes and the EX branch-resolution signal.
- Drives per-stage pipeline-register load enables and bubble/flush controls, so no datapath stage decides its own stall.
- Registered FSM with Mealy outputs, which allows same-cycle freeze.

Parameters:
- CNT_WIDTH, 32, width of the optional performance counters.

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- load_use_hazard  input  1  load in MEM with a dependent consumer in EX (the MEM_EX_rdata_hazard flag)
- imem_read  input  1  IF-stage fetch request
- imem_resp  input  1  icache data valid this cycle
- dmem_req  input  1  MEM-stage read or write request
- dmem_resp  input  1  dcache access complete this cycle
- br_taken  input  1  EX-stage branch/jump redirect
- pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  output  1 each  register load enables
- if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  load a NOP bubble into that register; only effective when its load is 1
- stall  output  1  any of pc_load..mem_wb_load deasserted
- stall_cycles  output  CNT_WIDTH  optional perf counter
- flush_events  output  CNT_WIDTH  optional perf counter

Behaviour:
- Reset:
  - State is RUN.
  - While rst_n is low, all load enables and flushes are 0 and stall=0.
  - Counters clear to 0.
  - Reset asserted mid-stall abandons the stall immediately; no pending handshake is remembered.
- Pending conditions:
  - dpend = dmem_req & ~dmem_resp
  - ipend = imem_read & ~imem_resp
- States: RUN, DC_WAIT, IC_WAIT, LU_STALL.
- Priority each cycle is fixed:
  - dpend (freeze) > ipend (freeze) > load-use (bubble) > br_taken (flush) > normal.
- Freeze:
  - All five load enables are 0, all flushes are 0, stall=1.
  - Next state is DC_WAIT if dpend, else IC_WAIT.
- DC_WAIT / IC_WAIT:
  - Freeze is held while the corresponding pend is true.
  - In the resp cycle, outputs are evaluated as RUN with that pend false. A still-pending other cache moves to the other WAIT state. This gives zero added latency after resp.
- Load-use, only from RUN or a WAIT resp cycle:
  - pc_load, if_id_load and id_ex_load are 0.
  - ex_mem_load=1 with ex_mem_flush=1.
  - mem_wb_load=1, stall=1.
  - Next state is LU_STALL.
- LU_STALL:
  - load_use_hazard is ignored for exactly one cycle, guaranteeing forward progress. The load then sits in WB and WB forwarding supplies the data.
  - Otherwise the cycle is evaluated as RUN, including freeze and br_taken.
  - Next state is RUN, or a WAIT state.
- br_taken, not frozen and no load-use:
  - All loads are 1, if_id_flush=1, id_ex_flush=1, stall=0.
  - br_taken during a freeze is not latched. EX holds its content, so br_taken is re-presented when the freeze releases.
- Normal cycle: all loads are 1, all flushes are 0.
- Simultaneous dmem_resp and imem_resp in a freeze cycle: both clear and the state returns to RUN.
- Outputs are combinational from state and inputs. Only the state and the counters are flops.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on every cycle with stall=1 and rst_n high.
  - flush_events increments on each cycle with if_id_flush=1.
  - Both wrap modulo 2^CNT_WIDTH.
- Undefined:
  - Both outputs are tied to 0 and no counter flops are synthesized.
  - Ports remain, so the instantiation does not change.

Test Plan:
- dmem_req=1 with dmem_resp arriving 3 cycles later -> all loads 0 for 3 cycles in DC_WAIT, then all loads 1 in the resp cycle, then state RUN; stall_cycles=3 with the macro defined.
- load_use_hazard held high for 2 cycles -> cycle 1: pc/if_id/id_ex loads 0 with ex_mem_flush=1; cycle 2 (LU_STALL): hazard ignored, all loads 1.
- br_taken=1 alone -> if_id_flush=1, id_ex_flush=1, all loads 1, flush_events increments by 1.
- dmem and imem both pending, dmem_resp at cycle 2, imem_resp at cycle 4 -> DC_WAIT, then IC_WAIT, then RUN; loads 0 for cycles 0 through 3.
- br_taken with dpend in the same cycle -> freeze only, no flush; br_taken held until resp -> flush occurs in the resp cycle.
- rst_n pulsed low during DC_WAIT -> outputs go 0 immediately; after release the state is RUN and counters are 0.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Hazard sequencer for the 5-stage pipeline: combinational (Mealy) stage enables from a registered state.
// Optional perf counters are enabled by defining STALL_PERF_CNT_EN.
module pipeline_stall_controller #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_use_hazard,
   input  logic                 imem_read,
   input  logic                 imem_resp,
   input  logic                 dmem_req,
   input  logic                 dmem_resp,
   input  logic                 br_taken,
   output logic                 pc_load,
   output logic                 if_id_load,
   output logic                 id_ex_load,
   output logic                 ex_mem_load,
   output logic                 mem_wb_load,
   output logic                 if_id_flush,
   output logic                 id_ex_flush,
   output logic                 ex_mem_flush,
   output logic                 stall,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] flush_events
);

   typedef enum logic [1:0] {RUN, DC_WAIT, IC_WAIT, LU_STALL} state_t;

   state_t state_q, state_d;
   logic   dpend, ipend, lu_ok;

   assign dpend = dmem_req & ~dmem_resp;
   assign ipend = imem_read & ~imem_resp;
   // The hazard is masked for the one cycle after a bubble so the load can reach WB.
   assign lu_ok = load_use_hazard & (state_q != LU_STALL);

   always_comb begin
      state_d      = RUN;
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      id_ex_load   = 1'b0;
      ex_mem_load  = 1'b0;
      mem_wb_load  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      if (!rst_n) begin
         state_d = RUN;
      end else if (dpend || ipend) begin
         state_d = dpend ? DC_WAIT : IC_WAIT;
      end else if (lu_ok) begin
         state_d      = LU_STALL;
         ex_mem_load  = 1'b1;
         ex_mem_flush = 1'b1;
         mem_wb_load  = 1'b1;
      end else begin
         state_d     = RUN;
         pc_load     = 1'b1;
         if_id_load  = 1'b1;
         id_ex_load  = 1'b1;
         ex_mem_load = 1'b1;
         mem_wb_load = 1'b1;
         if_id_flush = br_taken;
         id_ex_flush = br_taken;
      end
   end

   assign stall = rst_n & ~(pc_load & if_id_load & id_ex_load & ex_mem_load & mem_wb_load);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

`ifdef STALL_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_WIDTH-1:0] flush_events_q, flush_events_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q + CNT_WIDTH'(stall);
      flush_events_d = flush_events_q + CNT_WIDTH'(if_id_flush);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;
`else
   assign stall_cycles = '0;
   assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller; counters expected to count only when STALL_PERF_CNT_EN is defined.
module tb_pipeline_stall_controller;

   localparam int CW = 32;
   // stimulus bits {dmem_req, dmem_resp, imem_read, imem_resp, load_use_hazard, br_taken}
   localparam logic [5:0] D_REQ = 6'b100000, D_RSP = 6'b010000, I_REQ = 6'b001000,
                          I_RSP = 6'b000100, LU = 6'b000010, BR = 6'b000001, IDLE = 6'b000000;
   // outputs {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, ex_mem_flush, stall}
   localparam logic [8:0] O_NORM = 9'b11111_000_0, O_FRZ = 9'b00000_000_1,
                          O_LU = 9'b00011_001_1, O_BR = 9'b11111_110_0, O_RST = 9'b0;

   logic clk = 1'b0;
   logic rst_n;
   logic load_use_hazard, imem_read, imem_resp, dmem_req, dmem_resp, br_taken;
   logic pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
   logic if_id_flush, id_ex_flush, ex_mem_flush, stall;
   logic [CW-1:0] stall_cycles, flush_events;

   int checks = 0;
   int failures = 0;
   logic [CW-1:0] exp_sc = '0;
   logic [CW-1:0] exp_fe = '0;

   always #5 clk = ~clk;

   pipeline_stall_controller #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .load_use_hazard(load_use_hazard),
      .imem_read(imem_read), .imem_resp(imem_resp), .dmem_req(dmem_req),
      .dmem_resp(dmem_resp), .br_taken(br_taken), .pc_load(pc_load),
      .if_id_load(if_id_load), .id_ex_load(id_ex_load), .ex_mem_load(ex_mem_load),
      .mem_wb_load(mem_wb_load), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .stall(stall), .stall_cycles(stall_cycles),
      .flush_events(flush_events)
   );

   wire [8:0] outs = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                      if_id_flush, id_ex_flush, ex_mem_flush, stall};

   task automatic drive(input logic [5:0] s);
      {dmem_req, dmem_resp, imem_read, imem_resp, load_use_hazard, br_taken} = s;
   endtask

   // Drives one cycle, samples outputs mid-cycle, and advances the counter model with the expected outputs.
   task automatic cyc(input logic [5:0] s, input logic [8:0] e, output logic [8:0] o);
      drive(s);
      @(negedge clk);
      o = outs;
      @(posedge clk);
`ifdef STALL_PERF_CNT_EN
      exp_sc = exp_sc + CW'(e[0]);
      exp_fe = exp_fe + CW'(e[3]);
`endif
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(6'b111111);
      #3;
      checks++;
      if (outs !== O_RST) begin failures++; $display("FAIL reset_outs outs=%b exp=%b", outs, O_RST); end
      checks++;
      if (stall_cycles !== '0 || flush_events !== '0) begin
         failures++; $display("FAIL reset_cnt sc=%0d fe=%0d exp=0", stall_cycles, flush_events);
      end
      @(negedge clk);
      drive(IDLE);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_dcache_wait();
      logic [5:0] s [5];
      logic [8:0] e [5];
      logic [8:0] o;
      s = '{D_REQ, D_REQ, D_REQ, D_REQ | D_RSP, IDLE};
      e = '{O_FRZ, O_FRZ, O_FRZ, O_NORM, O_NORM};
      for (int i = 0; i < 5; i++) begin
         cyc(s[i], e[i], o);
         checks++;
         if (o !== e[i]) begin failures++; $display("FAIL dcache_wait cyc%0d outs=%b exp=%b", i, o, e[i]); end
      end
      checks++;
      if (stall_cycles !== exp_sc) begin failures++; $display("FAIL dcache_stall_cnt got=%0d exp=%0d", stall_cycles, exp_sc); end
   endtask

   task automatic test_load_use();
      logic [5:0] s [10];
      logic [8:0] e [10];
      logic [8:0] o;
      s = '{LU, LU, LU, IDLE, LU | BR, LU | BR, LU, D_REQ, D_REQ | D_RSP | LU, IDLE};
      e = '{O_LU, O_NORM, O_LU, O_NORM, O_LU, O_BR, O_LU, O_FRZ, O_LU, O_NORM};
      for (int i = 0; i < 10; i++) begin
         cyc(s[i], e[i], o);
         checks++;
         if (o !== e[i]) begin failures++; $display("FAIL load_use cyc%0d outs=%b exp=%b", i, o, e[i]); end
      end
   endtask

   task automatic test_branch();
      logic [8:0] o;
      cyc(BR, O_BR, o);
      checks++;
      if (o !== O_BR) begin failures++; $display("FAIL branch outs=%b exp=%b", o, O_BR); end
      cyc(IDLE, O_NORM, o);
      checks++;
      if (o !== O_NORM) begin failures++; $display("FAIL branch_after outs=%b exp=%b", o, O_NORM); end
      checks++;
      if (flush_events !== exp_fe) begin failures++; $display("FAIL flush_cnt got=%0d exp=%0d", flush_events, exp_fe); end
      checks++;
      if (stall_cycles !== exp_sc) begin failures++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cycles, exp_sc); end
   endtask

   task automatic test_both_pending();
      logic [5:0] s [8];
      logic [8:0] e [8];
      logic [8:0] o;
      s = '{D_REQ | I_REQ, D_REQ | I_REQ, D_REQ | D_RSP | I_REQ, I_REQ, I_REQ | I_RSP,
            D_REQ | I_REQ, D_REQ | D_RSP | I_REQ | I_RSP, IDLE};
      e = '{O_FRZ, O_FRZ, O_FRZ, O_FRZ, O_NORM, O_FRZ, O_NORM, O_NORM};
      for (int i = 0; i < 8; i++) begin
         cyc(s[i], e[i], o);
         checks++;
         if (o !== e[i]) begin failures++; $display("FAIL both_pending cyc%0d outs=%b exp=%b", i, o, e[i]); end
      end
   endtask

   task automatic test_br_during_freeze();
      logic [5:0] s [5];
      logic [8:0] e [5];
      logic [8:0] o;
      s = '{D_REQ | BR, D_REQ | BR, D_REQ | D_RSP | BR, IDLE, I_REQ | BR};
      e = '{O_FRZ, O_FRZ, O_BR, O_NORM, O_FRZ};
      for (int i = 0; i < 5; i++) begin
         cyc(s[i], e[i], o);
         checks++;
         if (o !== e[i]) begin failures++; $display("FAIL br_freeze cyc%0d outs=%b exp=%b", i, o, e[i]); end
      end
      cyc(I_RSP | I_REQ, O_NORM, o);
      checks++;
      if (o !== O_NORM) begin failures++; $display("FAIL br_not_latched outs=%b exp=%b", o, O_NORM); end
      checks++;
      if (flush_events !== exp_fe) begin failures++; $display("FAIL br_freeze_cnt got=%0d exp=%0d", flush_events, exp_fe); end
   endtask

   task automatic test_reset_mid_stall();
      logic [8:0] o;
      cyc(D_REQ, O_FRZ, o);
      checks++;
      if (o !== O_FRZ) begin failures++; $display("FAIL rst_mid_pre outs=%b exp=%b", o, O_FRZ); end
      rst_n = 1'b0;
      #1;
      exp_sc = '0;
      exp_fe = '0;
      checks++;
      if (outs !== O_RST) begin failures++; $display("FAIL rst_mid_outs outs=%b exp=%b", outs, O_RST); end
      checks++;
      if (stall_cycles !== '0 || flush_events !== '0) begin
         failures++; $display("FAIL rst_mid_cnt sc=%0d fe=%0d exp=0", stall_cycles, flush_events);
      end
      @(negedge clk);
      drive(IDLE);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc(LU, O_LU, o);
      checks++;
      if (o !== O_LU) begin failures++; $display("FAIL rst_mid_run outs=%b exp=%b", o, O_LU); end
      cyc(IDLE, O_NORM, o);
      checks++;
      if (o !== O_NORM) begin failures++; $display("FAIL rst_mid_idle outs=%b exp=%b", o, O_NORM); end
      checks++;
      if (stall_cycles !== exp_sc) begin failures++; $display("FAIL rst_mid_stall_cnt got=%0d exp=%0d", stall_cycles, exp_sc); end
   endtask

   initial begin
      test_reset();
      test_dcache_wait();
      test_load_use();
      test_branch();
      test_both_pending();
      test_br_during_freeze();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
